syn_current: RTL and testbench
==============================

# syn_current

Synapse stage between the presynaptic and postsynaptic LIF neurons. It converts presynaptic spikes into an 8-bit synaptic current that drives the postsynaptic neuron's `current` input. Each spike passes through a fixed axonal delay line, then adds the stored synaptic weight to a saturating current accumulator. The accumulator decays geometrically on a prescaled tick. The stored weight is reloaded from the STDP block whenever its update flag pulses.

## Interface

Parameters:
- `W_INIT`, 64: weight register value after reset (0..255).
- `DELAY`, 2: axonal delay in cycles, legal range 1..8.
- `DECAY_SHIFT`, 3: decay amount per tick is `I >> DECAY_SHIFT` (1..7).
- `DECAY_PERIOD`, 4: cycles between decay ticks (1..256).

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `pre_spike`  in  1  presynaptic spike, 1-cycle pulse or held level (sampled every cycle).
- `weight_in`  in  8  new weight from STDP block, unsigned.
- `weight_valid`  in  1  load strobe for `weight_in` (STDP update flag).
- `current_out`  out  8  registered synaptic current to the postsynaptic LIF.
- `weight_q`  out  8  current weight register value.
- `syn_event`  out  1  registered pulse: a delayed spike was applied this update.
- `sat_flag`  out  1  registered pulse: accumulator clipped at 255 this update.

## Operation

- **Reset** (`rst_n` low at a rising edge) sets the following, and overrides every other input:
  - `current_out` = 0, `syn_event` = 0, `sat_flag` = 0
  - `weight_q` = `W_INIT`
  - decay counter = 0
  - delay line cleared, so in-flight spikes are dropped.
- **Delay line:** a `DELAY`-stage shift register `d`.
  - `d[0] <= pre_spike`, and `d[i] <= d[i-1]`.
  - `arrival = d[DELAY-1]`.
- **Weight register:** if `weight_valid`, then `weight_q <= weight_in`.
  - An arrival in the same cycle uses the old `weight_q`; the new value applies from the next cycle.
- **Decay prescaler:** counter `cnt` runs 0..`DECAY_PERIOD-1` and wraps.
  - `tick = (cnt == DECAY_PERIOD-1)`.
  - With `DECAY_PERIOD` = 1, `tick` is high every cycle.
- **Accumulator update:** let `I` = `current_out`.
  - `dec = tick ? max(I >> DECAY_SHIFT, (I != 0) ? 1 : 0) : 0`. The minimum decrement of 1 guarantees decay to 0.
  - `add = arrival ? weight_q : 0`.
  - `sum = (I - dec) + add`, computed in 9 bits; `I - dec` never underflows.
  - `current_out <= (sum > 255) ? 255 : sum[7:0]`.
  - `sat_flag <= (sum > 255)`.
  - `syn_event <= arrival`.
- **Simultaneous tick and arrival:** decay is applied to the old `I` first, then the weight is added.
- **Zero weight:** an arrival with `weight_q` = 0 still pulses `syn_event` and leaves `current_out` unchanged apart from decay.
- No handshake back-pressure: every spike is applied, with no queueing beyond the delay line.

## Timing

- **Spike to current:** a `pre_spike` sampled at edge k reaches `arrival` after edge k+DELAY-1. It appears in `current_out` and `syn_event` after edge k+DELAY, giving a latency of `DELAY` cycles.
- **Weight load:** `weight_valid` sampled at edge k makes `weight_q` new after edge k. The new weight affects the first arrival evaluated at edge k+1 or later.
- **Decay tick timing:** the first tick after reset is evaluated at edge `DECAY_PERIOD` (counting the first post-reset edge as 1). Subsequent ticks follow every `DECAY_PERIOD` edges.
- **Held `pre_spike`:** held high, it produces one arrival per cycle after the initial `DELAY`.
- **Output registers:** all outputs are registers with no combinational input-to-output paths.

## Test plan

All scenarios use the default parameters.

1. **Single spike:** reset, then a 1-cycle `pre_spike` at edge k.
   - `current_out` = 0 through edge k+1; 64 after edge k+2; `syn_event` high for exactly that one cycle.
   - On each subsequent tick: 64→56→49→43.
2. **Saturation:** hold `pre_spike` high for 10 cycles.
   - `current_out` rises in steps of 64 (net of decay), clips at 255 and never wraps.
   - `sat_flag` pulses on each clipped update.
3. **Weight-load ordering:** `weight_valid` = 1 with `weight_in` = 200 in the same cycle an arrival is evaluated, starting from `I` = 0 and no tick.
   - `current_out` = 64 and `weight_q` = 200.
   - The next arrival, with no tick, gives 64 + 200 → 255 and `sat_flag` = 1.
4. **Small-value decay:** with `I` = 5 and no spikes, `current_out` on successive ticks is 5,4,3,2,1,0 and then stays 0.
5. **Simultaneous tick and arrival:** `I` = 80, tick coincident with an arrival, `weight_q` = 64.
   - `current_out` = 80 − 10 + 64 = 134.
6. **Reset mid-flight:** a spike sits in the delay line (1 cycle after `pre_spike`), `weight_q` = 200, `I` = 120; assert `rst_n` = 0 for one edge.
   - `current_out` = 0, `weight_q` = 64, and no `syn_event` ever appears for the dropped spike.

Source files
------------

// File: rtl/syn_current.sv
// Synapse stage: delays presynaptic spikes, adds the stored weight into a
// saturating current accumulator that decays geometrically on a prescaled tick.
module syn_current #(
  parameter int W_INIT       = 64,
  parameter int DELAY        = 2,
  parameter int DECAY_SHIFT  = 3,
  parameter int DECAY_PERIOD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pre_spike,
  input  logic [7:0] weight_in,
  input  logic       weight_valid,
  output logic [7:0] current_out,
  output logic [7:0] weight_q,
  output logic       syn_event,
  output logic       sat_flag
);

  logic [DELAY-1:0] d;
  logic [8:0]       cnt;
  logic             tick;
  logic             arrival;
  logic [7:0]       shifted;
  logic [7:0]       dec;
  logic [7:0]       add;
  logic [8:0]       sum;

  always_comb begin
    tick    = (cnt == 9'(DECAY_PERIOD - 1));
    arrival = d[DELAY-1];
    shifted = current_out >> DECAY_SHIFT;
    dec     = '0;
    // Minimum decrement of 1 so a small current always reaches zero.
    if (tick) dec = (shifted != '0) ? shifted : {7'd0, current_out != '0};
    add     = arrival ? weight_q : '0;
    sum     = {1'b0, current_out - dec} + {1'b0, add};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d           <= '0;
      cnt         <= '0;
      weight_q    <= 8'(W_INIT);
      current_out <= '0;
      syn_event   <= 1'b0;
      sat_flag    <= 1'b0;
    end else begin
      d[0] <= pre_spike;
      for (int unsigned i = 1; i < DELAY; i++) d[i] <= d[i-1];
      cnt <= tick ? '0 : cnt + 9'd1;
      if (weight_valid) weight_q <= weight_in;
      current_out <= sum[8] ? 8'hFF : sum[7:0];
      sat_flag    <= sum[8];
      syn_event   <= arrival;
    end
  end

endmodule

// File: tb/tb_syn_current.sv
// Bench for syn_current: cycle model feeds a scoreboard queue checked on the
// falling edge, plus directed scenario checks against hand-derived values.
module tb_syn_current;

  localparam int P_W_INIT = 64;
  localparam int P_DELAY  = 2;
  localparam int P_SHIFT  = 3;
  localparam int P_PERIOD = 4;

  typedef struct {
    logic [7:0] cur;
    logic [7:0] w;
    logic       ev;
    logic       sat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pre_spike = 1'b0;
  logic [7:0] weight_in = '0;
  logic       weight_valid = 1'b0;
  logic [7:0] current_out;
  logic [7:0] weight_q;
  logic       syn_event;
  logic       sat_flag;

  int checks = 0;
  int fails  = 0;
  exp_t sb[$];

  // reference model state
  logic [P_DELAY-1:0] m_d;
  int                 m_cnt;
  int                 m_i;
  int                 m_w;
  logic               m_ev;
  logic               m_sat;

  syn_current #(
    .W_INIT(P_W_INIT),
    .DELAY(P_DELAY),
    .DECAY_SHIFT(P_SHIFT),
    .DECAY_PERIOD(P_PERIOD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pre_spike(pre_spike),
    .weight_in(weight_in),
    .weight_valid(weight_valid),
    .current_out(current_out),
    .weight_q(weight_q),
    .syn_event(syn_event),
    .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, advance the model, push its expectation.
  task automatic step(input logic rst, input logic pre, input logic wv, input logic [7:0] win);
    int   dec, sum;
    logic arr;
    exp_t e;
    rst_n = rst; pre_spike = pre; weight_valid = wv; weight_in = win;
    if (!rst) begin
      m_d = '0; m_cnt = 0; m_i = 0; m_w = P_W_INIT; m_ev = 0; m_sat = 0;
    end else begin
      arr = m_d[P_DELAY-1];
      dec = 0;
      if (m_cnt == P_PERIOD - 1) begin
        dec = m_i >> P_SHIFT;
        if (dec == 0 && m_i != 0) dec = 1;
      end
      sum   = (m_i - dec) + (arr ? m_w : 0);
      m_sat = (sum > 255);
      m_i   = m_sat ? 255 : sum;
      m_ev  = arr;
      if (wv) m_w = win;
      m_d   = {m_d[P_DELAY-2:0], pre};
      m_cnt = (m_cnt == P_PERIOD - 1) ? 0 : m_cnt + 1;
    end
    e.cur = 8'(m_i); e.w = 8'(m_w); e.ev = m_ev; e.sat = m_sat;
    @(posedge clk);
    sb.push_back(e);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, '0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checks++;
      if (current_out !== e.cur || weight_q !== e.w || syn_event !== e.ev || sat_flag !== e.sat) begin
        fails++;
        $display("FAIL scoreboard t=%0t: got cur=%0d w=%0d ev=%b sat=%b, expected cur=%0d w=%0d ev=%b sat=%b",
                 $time, current_out, weight_q, syn_event, sat_flag, e.cur, e.w, e.ev, e.sat);
      end
    end
  end

  task automatic test_reset();
    step(0, 1, 1, 8'd99);
    step(0, 0, 0, '0);
    checks++;
    if (current_out !== 8'd0 || weight_q !== 8'd64 || syn_event !== 1'b0 || sat_flag !== 1'b0) begin
      fails++;
      $display("FAIL reset: cur=%0d w=%0d ev=%b sat=%b, expected 0 64 0 0", current_out, weight_q, syn_event, sat_flag);
    end
  endtask

  task automatic test_single_spike();
    logic [7:0] got[1:12];
    logic       ev[1:12];
    step(0, 0, 0, '0);
    step(1, 1, 0, '0);
    got[1] = current_out; ev[1] = syn_event;
    for (int unsigned k = 2; k <= 12; k++) begin
      step(1, 0, 0, '0);
      got[k] = current_out; ev[k] = syn_event;
    end
    checks++;
    if (got[1] !== 8'd0 || got[2] !== 8'd0) begin
      fails++; $display("FAIL spike_latency: cur e1=%0d e2=%0d, expected 0 0", got[1], got[2]);
    end
    checks++;
    if (got[3] !== 8'd64 || ev[3] !== 1'b1 || ev[2] !== 1'b0 || ev[4] !== 1'b0) begin
      fails++; $display("FAIL spike_arrival: cur=%0d ev e2/e3/e4=%b%b%b, expected 64 ev 010", got[3], ev[2], ev[3], ev[4]);
    end
    checks++;
    if (got[4] !== 8'd56 || got[7] !== 8'd56 || got[8] !== 8'd49 || got[12] !== 8'd43) begin
      fails++; $display("FAIL spike_decay: got %0d %0d %0d %0d, expected 56 56 49 43", got[4], got[7], got[8], got[12]);
    end
  endtask

  task automatic test_saturation();
    int sat_cnt = 0;
    int wrap = 0;
    step(0, 0, 0, '0);
    for (int unsigned k = 1; k <= 12; k++) begin
      step(1, k <= 10, 0, '0);
      if (sat_flag) sat_cnt++;
      if (sat_flag && current_out !== 8'd255) wrap++;
    end
    checks++;
    if (current_out !== 8'd255 || sat_flag !== 1'b1) begin
      fails++; $display("FAIL sat_final: cur=%0d sat=%b, expected 255 1", current_out, sat_flag);
    end
    checks++;
    if (sat_cnt != 6 || wrap != 0) begin
      fails++; $display("FAIL sat_pulses: got %0d pulses %0d non-255, expected 6 0", sat_cnt, wrap);
    end
    step(1, 0, 0, '0);
    checks++;
    if (current_out !== 8'd255 || sat_flag !== 1'b0 || syn_event !== 1'b0) begin
      fails++; $display("FAIL sat_release: cur=%0d sat=%b ev=%b, expected 255 0 0", current_out, sat_flag, syn_event);
    end
  endtask

  task automatic test_weight_order();
    step(0, 0, 0, '0);
    step(1, 0, 0, '0);
    step(1, 0, 0, '0);
    step(1, 1, 0, '0);
    step(1, 1, 0, '0);
    step(1, 0, 1, 8'd200);
    checks++;
    if (current_out !== 8'd64 || weight_q !== 8'd200) begin
      fails++; $display("FAIL weight_order: cur=%0d w=%0d, expected 64 200", current_out, weight_q);
    end
    step(1, 0, 0, '0);
    checks++;
    if (current_out !== 8'd255 || sat_flag !== 1'b1) begin
      fails++; $display("FAIL weight_new: cur=%0d sat=%b, expected 255 1", current_out, sat_flag);
    end
  endtask

  task automatic test_small_decay();
    logic [7:0] exp_seq[6] = '{8'd4, 8'd3, 8'd2, 8'd1, 8'd0, 8'd0};
    step(0, 0, 0, '0);
    step(1, 1, 1, 8'd5);
    step(1, 0, 0, '0);
    step(1, 0, 0, '0);
    checks++;
    if (current_out !== 8'd5) begin
      fails++; $display("FAIL small_start: cur=%0d, expected 5", current_out);
    end
    for (int unsigned t = 0; t < 6; t++) begin
      step(1, 0, 0, '0);
      checks++;
      if (current_out !== exp_seq[t]) begin
        fails++; $display("FAIL small_decay[%0d]: cur=%0d, expected %0d", t, current_out, exp_seq[t]);
      end
      idle(3);
    end
  endtask

  task automatic test_simultaneous();
    step(0, 0, 0, '0);
    step(1, 1, 1, 8'd80);
    step(1, 1, 0, '0);
    step(1, 0, 1, 8'd64);
    checks++;
    if (current_out !== 8'd80) begin
      fails++; $display("FAIL simul_pre: cur=%0d, expected 80", current_out);
    end
    step(1, 0, 0, '0);
    checks++;
    if (current_out !== 8'd134 || syn_event !== 1'b1) begin
      fails++; $display("FAIL simul_tick_arrival: cur=%0d ev=%b, expected 134 1", current_out, syn_event);
    end
  endtask

  task automatic test_reset_midflight();
    int ev_seen = 0;
    step(0, 0, 0, '0);
    step(1, 1, 1, 8'd120);
    step(1, 0, 0, '0);
    step(1, 1, 1, 8'd200);
    checks++;
    if (current_out !== 8'd120 || weight_q !== 8'd200) begin
      fails++; $display("FAIL midflight_setup: cur=%0d w=%0d, expected 120 200", current_out, weight_q);
    end
    step(0, 0, 0, '0);
    checks++;
    if (current_out !== 8'd0 || weight_q !== 8'd64) begin
      fails++; $display("FAIL midflight_reset: cur=%0d w=%0d, expected 0 64", current_out, weight_q);
    end
    for (int unsigned k = 0; k < 5; k++) begin
      step(1, 0, 0, '0);
      if (syn_event) ev_seen++;
    end
    checks++;
    if (ev_seen != 0 || current_out !== 8'd0) begin
      fails++; $display("FAIL midflight_drop: events=%0d cur=%0d, expected 0 0", ev_seen, current_out);
    end
  endtask

  task automatic test_back_to_back();
    step(0, 0, 0, '0);
    for (int unsigned k = 0; k < 300; k++)
      step(($urandom_range(0, 49) != 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 9) == 0), 8'($urandom_range(0, 255)));
    idle(4);
  endtask

  initial begin
    test_reset();
    test_single_spike();
    test_saturation();
    test_weight_order();
    test_small_decay();
    test_simultaneous();
    test_reset_midflight();
    test_back_to_back();
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      fails++; $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
